cc_serializer: RTL and testbench

CC_SERIALIZER -- requirements
Module: cc_serializer

---
 rtl/cc_serializer.sv | 125 ++++++++++++
 tb/tb_cc_serializer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_serializer.sv
// -----------------------------------------------------------------------------
// cc_serializer
//
// Pops 512-bit cache lines from a first-word-fall-through hit data FIFO and
// streams each one as eight 64-bit beats over a valid/ready interface. The
// beats go in critical-word-first order: the first beat is the word addressed
// by the byte offset stored with the line, and the order then wraps modulo 8.
// Back-to-back lines stream with no idle cycle between them.
//
// Ports
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset
//   fifo_empty_i   FIFO empty flag
//   fifo_aempty_i  FIFO almost-empty flag (not used)
//   fifo_rdata_i   FIFO head: [517:512] byte offset, [511:0] line data
//   fifo_rden_o    pop strobe; the head entry is consumed on this edge
//   rdata_o        beat data
//   rlast_o        last beat of the line
//   rvalid_o       beat valid
//   rready_i       downstream ready
// -----------------------------------------------------------------------------
module cc_serializer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fifo_empty_i,
  input  logic         fifo_aempty_i,
  input  logic [517:0] fifo_rdata_i,
  output logic         fifo_rden_o,
  output logic [63:0]  rdata_o,
  output logic         rlast_o,
  output logic         rvalid_o,
  input  logic         rready_i
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [511:0] line_q,  line_d;
  logic [2:0]   start_q, start_d;
  logic [2:0]   cnt_q,   cnt_d;
  logic         pop;
  logic [2:0]   word_idx;
  logic [63:0]  word;

  // The almost-empty flag and the low offset bits carry no function here.
  logic unused_inputs;
  assign unused_inputs = fifo_aempty_i ^ (^fifo_rdata_i[514:512]);

  // Next-state logic.
  // NOTE: every signal written below gets its default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty_i) begin
          pop     = 1'b1;
          line_d  = fifo_rdata_i[511:0];
          start_d = fifo_rdata_i[517:515];
          cnt_d   = 3'd0;
          state_d = SEND;
        end
      end

      SEND: begin
        if (rready_i) begin
          if (cnt_q == 3'd7) begin
            cnt_d = 3'd0;
            if (!fifo_empty_i) begin
              // Reload in the cycle the last beat completes: no bubble.
              pop     = 1'b1;
              line_d  = fifo_rdata_i[511:0];
              start_d = fifo_rdata_i[517:515];
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      start_q <= 3'd0;
      // NOTE: the line register is reset as well so that rdata_o reads zero
      // coming out of reset instead of stale data from an abandoned line.
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      line_q  <= line_d;
    end
  end

  // 3-bit add wraps naturally, giving the critical-word-first rotation.
  assign word_idx = start_q + cnt_q;
  assign word     = line_q[{word_idx, 6'b0} +: 64];

  // Outputs are forced idle while reset is held, so nothing is popped or
  // presented during the reset cycle itself.
  assign fifo_rden_o = rst_n & pop;
  assign rvalid_o    = rst_n & (state_q == SEND);
  assign rlast_o     = rvalid_o & (cnt_q == 3'd7);
  assign rdata_o     = rst_n ? word : 64'd0;

endmodule

// File: tb/tb_cc_serializer.sv
// -----------------------------------------------------------------------------
// tb_cc_serializer
//
// Self-checking bench for cc_serializer. The bench owns a FIFO model (queue of
// 518-bit entries) and a queue of expected beats. Whenever a pop is due, the
// popped line is expanded into its eight beats in wrap order from the start
// word. Each cycle, on the falling edge, the DUT outputs are compared to the
// head of that queue. Directed phases pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_cc_serializer;

  logic         clk;
  logic         rst_n;
  logic         fifo_empty_i;
  logic         fifo_aempty_i;
  logic [517:0] fifo_rdata_i;
  logic         fifo_rden_o;
  logic [63:0]  rdata_o;
  logic         rlast_o;
  logic         rvalid_o;
  logic         rready_i;

  cc_serializer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty_i (fifo_empty_i),
    .fifo_aempty_i(fifo_aempty_i),
    .fifo_rdata_i (fifo_rdata_i),
    .fifo_rden_o  (fifo_rden_o),
    .rdata_o      (rdata_o),
    .rlast_o      (rlast_o),
    .rvalid_o     (rvalid_o),
    .rready_i     (rready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic [517:0] fifo_q[$];
  beat_t        exp_q[$];
  logic [63:0]  log_data[$];
  logic         log_last[$];
  int           log_cyc[$];
  int           n_vec = 0;
  int           n_miss = 0;
  int           cyc = 0;
  int           rden_cnt = 0;
  int           valid_cnt = 0;

  localparam logic [63:0] BASE = 64'h0123_4567_89AB_CD00;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [517:0] make_line(input logic [5:0] off,
                                             input logic [63:0] base);
    logic [517:0] e;
    e[517:512] = off;
    for (int k = 0; k < 8; k++) e[64*k +: 64] = base | 64'(k);
    return e;
  endfunction

  function automatic logic [517:0] rand_line();
    logic [517:0] e;
    for (int k = 0; k < 17; k++) e[32*k +: 32] = $urandom();
    e[517:512] = 6'($urandom_range(0, 63));
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Model and compare process: runs on the falling edge, when the inputs for
  // the coming rising edge are already settled.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    int           sz;
    logic         exp_rden;
    logic [517:0] e;
    int           st;
    int           w;
    beat_t        b;

    sz = exp_q.size();
    // A line is popped only when no beat would remain outstanding after
    // this edge.
    exp_rden = rst_n && !fifo_empty_i &&
               (sz == 0 || (sz == 1 && rready_i));
    check("rden", 64'(fifo_rden_o), 64'(exp_rden));
    if (fifo_rden_o) rden_cnt++;
    if (rvalid_o) valid_cnt++;

    if (!rst_n) begin
      check("rst_rvalid", 64'(rvalid_o), 64'd0);
      check("rst_rlast", 64'(rlast_o), 64'd0);
      check("rst_rdata", rdata_o, 64'd0);
      exp_q.delete();
    end else begin
      check("rvalid", 64'(rvalid_o), 64'(sz != 0));
      if (sz != 0) begin
        check("rdata", rdata_o, exp_q[0].data);
        check("rlast", 64'(rlast_o), 64'(exp_q[0].last));
        if (rready_i) begin
          log_data.push_back(exp_q[0].data);
          log_last.push_back(exp_q[0].last);
          log_cyc.push_back(cyc);
          void'(exp_q.pop_front());
        end
      end
      if (exp_rden) begin
        e  = fifo_q.pop_front();
        st = int'(e[517:515]);
        for (int n = 0; n < 8; n++) begin
          w      = (st + n) % 8;
          b.data = e[64*w +: 64];
          b.last = (n == 7);
          exp_q.push_back(b);
        end
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic refresh();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    refresh();
  endtask

  task automatic push(input logic [517:0] e);
    fifo_q.push_back(e);
    refresh();
  endtask

  task automatic clear_log();
    log_data.delete();
    log_last.delete();
    log_cyc.delete();
    rden_cnt  = 0;
    valid_cnt = 0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(n < budget), 64'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int i;
    rst_n         = 1'b0;
    rready_i      = 1'b1;
    fifo_aempty_i = 1'b0;
    refresh();

    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Critical word 0, full-rate stream.
    clear_log();
    push(make_line(6'h00, BASE));
    drain("drain_a", 40);
    check("a_beats", 64'(log_data.size()), 64'd8);
    if (log_data.size() == 8) begin
      check("a_first", log_data[0], 64'h0123_4567_89AB_CD00);
      check("a_last", log_data[7], 64'h0123_4567_89AB_CD07);
      check("a_last_flag", 64'(log_last[7]), 64'd1);
      check("a_not_last", 64'(log_last[6]), 64'd0);
      check("a_span", 64'(log_cyc[7] - log_cyc[0]), 64'd7);
    end
    check("a_pops", 64'(rden_cnt), 64'd1);

    // Offset 0x2D: start word 5.
    clear_log();
    push(make_line(6'h2D, BASE));
    drain("drain_b", 40);
    check("b_beats", 64'(log_data.size()), 64'd8);
    if (log_data.size() == 8) begin
      check("b_first", log_data[0], 64'h0123_4567_89AB_CD05);
      check("b_wrap", log_data[3], 64'h0123_4567_89AB_CD00);
      check("b_last", log_data[7], 64'h0123_4567_89AB_CD04);
    end

    // Stalls with rready pattern 1,0,0,1,...
    clear_log();
    push(make_line(6'h13, 64'hFEDC_BA98_0000_0000));
    i = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && i < 100) begin
      rready_i = (i % 4 == 0) || (i % 4 == 3);
      tick();
      i++;
    end
    check("c_done", 64'(i < 100), 64'd1);
    check("c_beats", 64'(log_data.size()), 64'd8);
    check("c_stall_cycles", 64'(valid_cnt), 64'd16);
    rready_i = 1'b1;
    repeat (2) tick();

    // Two queued lines back to back.
    clear_log();
    push(make_line(6'h08, 64'hAAAA_0000_0000_0000));
    push(make_line(6'h38, 64'hBBBB_0000_0000_0000));
    drain("drain_d", 60);
    check("d_beats", 64'(log_data.size()), 64'd16);
    if (log_data.size() == 16) begin
      check("d_span", 64'(log_cyc[15] - log_cyc[0]), 64'd15);
      check("d_second_first", log_data[8], 64'hBBBB_0000_0000_0007);
    end
    check("d_pops", 64'(rden_cnt), 64'd2);

    // Reset while beat 3 is presented.
    clear_log();
    push(make_line(6'h00, 64'hCCCC_0000_0000_0000));
    i = 0;
    while (log_data.size() < 3 && i < 40) begin
      tick();
      i++;
    end
    check("e_reach_beat3", 64'(i < 40), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("e_abandoned", 64'(log_data.size()), 64'd3);
    push(make_line(6'h18, 64'hDDDD_0000_0000_0000));
    drain("drain_e", 40);
    check("e_beats", 64'(log_data.size()), 64'd11);
    if (log_data.size() == 11)
      check("e_restart", log_data[3], 64'hDDDD_0000_0000_0003);

    // Empty FIFO throughout, almost-empty toggling.
    clear_log();
    for (int k = 0; k < 20; k++) begin
      fifo_aempty_i = k[0];
      tick();
    end
    check("f_no_pop", 64'(rden_cnt), 64'd0);
    check("f_no_valid", 64'(valid_cnt), 64'd0);
    fifo_aempty_i = 1'b0;

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 4) == 0 && fifo_q.size() < 3) push(rand_line());
      rready_i      = ($urandom_range(0, 3) != 0);
      fifo_aempty_i = 1'($urandom_range(0, 1));
      rst_n         = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n    = 1'b1;
    rready_i = 1'b1;
    drain("drain_rand", 100);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
